fpdiv_ctrl: RTL and testbench

Control sequencer for the Goldschmidt fpdiv datapath. It drives en_a, en_b, en_rem, sel_mux3, sel_mux4 and rm into fpdiv. These signals are currently hand-sequenced by the bench.
- Accepts a start request and runs the fixed iteration schedule.
- Issues a single-cycle done pulse when final_ans is ready to be sampled.
- Sits beside fpdiv in the FP divide top level.

---
 rtl/fpdiv_ctrl.sv | 95 +++++++++
 tb/tb_fpdiv_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Goldschmidt fpdiv control sequencer; define FPDIV_CTRL_ABORT_EN to add the abort input
module fpdiv_ctrl #(
  parameter int ITERATIONS = 6,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rm_in,
`ifdef FPDIV_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic [1:0]    sel_mux3,
  output logic [1:0]    sel_mux4,
  output logic          rm,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);
  typedef enum logic [2:0] {IDLE, INIT_N, INIT_D, ITER_A, ITER_B, REM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] iter_n;
  logic rm_n, kill;
  if (ITERATIONS < 2 || ITERATIONS > 15 || (1 << CW) <= ITERATIONS) begin : g_bad_params
    $error("fpdiv_ctrl: ITERATIONS=%0d illegal for CW=%0d", ITERATIONS, CW);
  end
`ifdef FPDIV_CTRL_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  always_comb begin
    state_n = state;
    iter_n = iter;
    rm_n = rm;
    case (state)
      IDLE: if (start) begin
        state_n = INIT_N;
        iter_n = CW'(1);
        rm_n = rm_in;
      end
      INIT_N: state_n = INIT_D;
      INIT_D: begin
        state_n = ITER_A;
        iter_n = CW'(2);
      end
      ITER_A: state_n = ITER_B;
      ITER_B: begin
        state_n = iter == CW'(ITERATIONS) ? REM : ITER_A;
        iter_n = iter == CW'(ITERATIONS) ? iter : iter + CW'(1);
      end
      REM: state_n = DONE;
      DONE: begin
        state_n = IDLE;
        iter_n = '0;
        rm_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (kill) begin
      state_n = IDLE;
      iter_n = '0;
      rm_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter <= '0;
      rm <= 1'b0;
      en_a <= 1'b0;
      en_b <= 1'b0;
      en_rem <= 1'b0;
      sel_mux3 <= 2'b00;
      sel_mux4 <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      iter <= iter_n;
      rm <= rm_n;
      en_a <= state_n == INIT_N || state_n == ITER_A;
      en_b <= state_n == INIT_D || state_n == ITER_B;
      en_rem <= state_n == REM;
      sel_mux3 <= state_n == REM ? 2'b10 : (state_n == ITER_A || state_n == ITER_B) ? 2'b01 : 2'b00;
      sel_mux4 <= state_n == INIT_D ? 2'b01 : (state_n == ITER_A || state_n == REM) ? 2'b10 :
                  state_n == ITER_B ? 2'b11 : 2'b00;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: per-cycle scoreboard bench for fpdiv_ctrl (default and ITERATIONS=2 instances)
module tb_fpdiv_ctrl;
  localparam int N = 6;
  typedef struct packed {
    logic [1:0] s4;
    logic [1:0] s3;
    logic a, b, r, rm, busy, done;
    logic [3:0] it;
  } out_t;
  typedef struct {
    logic start;
    logic rm_in;
    out_t exp;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, rm_in = 0, start2 = 0, abort = 0;
  logic en_a, en_b, en_rem, rm, busy, done;
  logic [1:0] sel_mux3, sel_mux4;
  logic [3:0] iter;
  logic en_a2, en_b2, en_rem2, rm2, busy2, done2;
  logic [1:0] sel_mux32, sel_mux42;
  logic [1:0] iter2;
  out_t q0[$], q1[$];
  int checks = 0, fails = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  fpdiv_ctrl #(.ITERATIONS(N), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rm_in(rm_in),
`ifdef FPDIV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .sel_mux3(sel_mux3), .sel_mux4(sel_mux4),
    .rm(rm), .busy(busy), .done(done), .iter(iter)
  );
  fpdiv_ctrl #(.ITERATIONS(2), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rm_in(rm_in),
`ifdef FPDIV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .en_a(en_a2), .en_b(en_b2), .en_rem(en_rem2), .sel_mux3(sel_mux32), .sel_mux4(sel_mux42),
    .rm(rm2), .busy(busy2), .done(done2), .iter(iter2)
  );
  function automatic out_t rec(int s4, int s3, int a, int b, int r, int rmv, int bz, int dn, int it);
    return '{2'(s4), 2'(s3), 1'(a), 1'(b), 1'(r), 1'(rmv), 1'(bz), 1'(dn), 4'(it)};
  endfunction
  function automatic void cmp(string nm, out_t act, out_t e);
    out_t m = '1;
    if (e.done) begin
      m.s4 = 2'b00;
      m.s3 = 2'b00;
    end
    checks++;
    if ((act & m) !== (e & m)) begin
      fails++;
      $display("FAIL %s t=%0t: got s4/s3/a/b/r/rm/busy/done/it=%b required %b", nm, $time, act, e);
    end
  endfunction
  task automatic push_op(bit which, int n, int r);
    out_t e[$];
    e.push_back('0);
    e.push_back(rec(0, 0, 1, 0, 0, r, 1, 0, 1));
    e.push_back(rec(1, 0, 0, 1, 0, r, 1, 0, 1));
    for (int i = 2; i <= n; i++) begin
      e.push_back(rec(2, 1, 1, 0, 0, r, 1, 0, i));
      e.push_back(rec(3, 1, 0, 1, 0, r, 1, 0, i));
    end
    e.push_back(rec(2, 2, 0, 0, 1, r, 1, 0, n));
    e.push_back(rec(0, 0, 0, 0, 0, r, 1, 1, n));
    foreach (e[k]) if (which) q1.push_back(e[k]); else q0.push_back(e[k]);
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    out_t e0, e1;
    e0 = q0.size() != 0 ? q0.pop_front() : '0;
    e1 = q1.size() != 0 ? q1.pop_front() : '0;
    cmp("dut_n6", {sel_mux4, sel_mux3, en_a, en_b, en_rem, rm, busy, done, iter}, e0);
    cmp("dut_n2", {sel_mux42, sel_mux32, en_a2, en_b2, en_rem2, rm2, busy2, done2, 2'b00, iter2}, e1);
  end
  initial begin
    vec_t tbl[$];
    tbl.push_back('{1'b1, 1'b1, rec(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{1'b0, 1'b0, rec(0, 0, 1, 0, 0, 1, 1, 0, 1)});
    tbl.push_back('{1'b1, 1'b0, rec(1, 0, 0, 1, 0, 1, 1, 0, 1)});
    for (int i = 2; i <= N; i++) begin
      tbl.push_back('{1'(i % 2), 1'b0, rec(2, 1, 1, 0, 0, 1, 1, 0, i)});
      tbl.push_back('{1'b0, 1'(i % 2), rec(3, 1, 0, 1, 0, 1, 1, 0, i)});
    end
    tbl.push_back('{1'b0, 1'b0, rec(2, 2, 0, 0, 1, 1, 1, 0, N)});
    tbl.push_back('{1'b1, 1'b1, rec(0, 0, 0, 0, 0, 1, 1, 1, N)});
    tbl.push_back('{1'b0, 1'b0, rec(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    step(1);
    chk_en = 1;
    step(2);
    reset = 0;
    step(10);
    for (int k = 0; k < tbl.size(); k++) begin
      start = tbl[k].start;
      rm_in = tbl[k].rm_in;
      q0.push_back(tbl[k].exp);
      step(1);
    end
    step(3);
    start = 1;
    rm_in = 0;
    push_op(0, N, 0);
    step(15);
    rm_in = 1;
    push_op(0, N, 1);
    step(15);
    push_op(0, N, 1);
    step(10);
    start = 0;
    step(8);
    start = 1;
    push_op(0, N, 1);
    step(1);
    start = 0;
    step(6);
    reset = 1;
    step(1);
    q0.delete();
    reset = 0;
    step(3);
    start = 1;
    rm_in = 0;
    push_op(0, N, 0);
    step(1);
    start = 0;
    step(16);
    start2 = 1;
    rm_in = 1;
    push_op(1, 2, 1);
    step(1);
    start2 = 0;
    rm_in = 0;
    step(8);
`ifdef FPDIV_CTRL_ABORT_EN
    start = 1;
    push_op(0, N, 0);
    step(1);
    start = 0;
    step(4);
    abort = 1;
    step(1);
    q0.delete();
    abort = 0;
    step(3);
    abort = 1;
    start = 1;
    rm_in = 1;
    push_op(0, N, 1);
    step(1);
    abort = 0;
    start = 0;
    step(16);
`endif
    chk_en = 0;
    checks++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL leftover_expect: got %0d pending records required 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
